// File: rtl/receptor_if.sv
// Serial receive link: the line into the receiver and the decoded word out of it.
// The master side drives rx and observes the results; the receiver takes the slave side.
interface receptor_if;
    logic        rx;
    logic [15:0] data;
    logic        done;
    logic        err;

    modport master (output rx, input data, input done, input err);
    modport slave  (input rx, output data, output done, output err);
endinterface

// File: rtl/receptor.sv
// Oversampling 8N1 UART receiver that assembles two bytes (low byte first) into a 16-bit word.
// It pulses done when a new word is available and pulses err when a frame is aborted.
module receptor #(
    parameter int OVS     = 16,
    parameter int GAP_MAX = 4
) (
    input  logic       clk_153k6hz,
    input  logic       rst_n,
    receptor_if.slave  bus
);
    localparam int CW = $clog2(OVS);
    localparam int GW = $clog2(GAP_MAX + 1);

    localparam logic [2:0] HUNT  = 3'd0;
    localparam logic [2:0] IDLE  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] DATA  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVS / 2 - 1);
    localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
    localparam logic [GW-1:0] GAP_ONE  = {{(GW-1){1'b0}}, 1'b1};
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_MAX - 1);

    logic          sync1_q, sync2_q;
    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          byte_q, byte_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    low_q, low_d;
    logic [15:0]   data_q, data_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          rxs_s;

    assign rxs_s    = sync2_q;
    assign bus.data = data_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

    // Next-state and output decode of the frame FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? CNT_ZERO : (cnt_q + CNT_ONE);
        bit_d   = bit_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        shift_d = shift_q;
        low_d   = low_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            HUNT: begin
                cnt_d = CNT_ZERO;
                if (rxs_s) state_d = IDLE;
                else       state_d = HUNT;
            end
            IDLE: begin
                cnt_d  = CNT_ZERO;
                byte_d = 1'b0;
                if (!rxs_s) state_d = START;
                else        state_d = IDLE;
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = CNT_ZERO;
                    bit_d = 3'd0;
                    if (!rxs_s)     state_d = DATA;
                    else if (byte_q) state_d = GAP;
                    else            state_d = IDLE;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                // cnt free-runs here so every data sample lands one bit time after the last
                if (cnt_q == CNT_MAX) begin
                    shift_d = {rxs_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                    else               state_d = DATA;
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d = CNT_ZERO;
                    if (!rxs_s) begin
                        err_d   = 1'b1;
                        state_d = HUNT;
                    end else if (!byte_q) begin
                        low_d   = shift_q;
                        byte_d  = 1'b1;
                        gap_d   = GAP_ZERO;
                        state_d = GAP;
                    end else begin
                        data_d  = {shift_q, low_q};
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            GAP: begin
                if (!rxs_s) begin
                    cnt_d   = CNT_ZERO;
                    state_d = START;
                end else if (cnt_q == CNT_MAX) begin
                    gap_d = gap_q + GAP_ONE;
                    if (gap_q == GAP_LAST) begin
                        err_d   = 1'b1;
                        low_d   = 8'h00;
                        byte_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = GAP;
                    end
                end else begin
                    state_d = GAP;
                end
            end
            default: begin
                cnt_d   = CNT_ZERO;
                state_d = HUNT;
            end
        endcase
    end

    // Input synchroniser and all FSM/datapath state
    always_ff @(posedge clk_153k6hz or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= HUNT;
            cnt_q   <= CNT_ZERO;
            bit_q   <= 3'd0;
            byte_q  <= 1'b0;
            gap_q   <= GAP_ZERO;
            shift_q <= 8'h00;
            low_q   <= 8'h00;
            data_q  <= 16'h0000;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
            low_q   <= low_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: doc/receptor.md
Name: receptor

Overview:
- UART receiver for the 2-byte, 8N1 link; the companion block on the far end transmits.
- Receives two consecutive bytes and assembles them into one 16-bit word:
  - first byte on the wire becomes the low byte, second byte the high byte;
  - each byte arrives LSB first.
- Oversamples the serial line for mid-bit sampling. Reports a complete word with a one-cycle done pulse and reports faults with a one-cycle err pulse.

Parameters:
- OVS, 16, clock cycles per bit time (even, ≥4); the default 16 means a 153.6 kHz clock for 9600 baud.
- GAP_MAX, 4, maximum idle bit times allowed between the stop bit of byte 0 and the start bit of byte 1.

Ports:
- clk_153k6hz  input  1  single clock, OVS × baud rate.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial line; idle high; asynchronous to clk_153k6hz.
- data  output  16  last good word; bits [7:0] = first byte received.
- done  output  1  one-cycle pulse: data has just been updated with a new word.
- err  output  1  one-cycle pulse: frame aborted (bad stop bit or inter-byte timeout).

Behaviour:
- Reset (async, rst_n=0):
  - data=16'h0000, done=0, err=0.
  - Synchroniser flops = 1; state=HUNT; bit counter, tick counter, byte index and shift register cleared.
- rx passes through a 2-flop synchroniser; all logic uses the synchronised rxs (2-cycle input latency).
- Tick counter cnt counts 0..OVS-1 and is cleared on every state entry, except as noted for DATA.
- States:
  - HUNT: wait for rxs=1, then go to IDLE. Guarantees that a reset or error in mid-frame never decodes a partial frame.
  - IDLE: byte index=0. When rxs=0, go to START with cnt=0.
  - START:
    - at cnt==OVS/2-1, sample rxs;
    - if 0, go to DATA with cnt=0 and bit=0;
    - if 1, false start: return to IDLE (byte 0) or GAP (byte 1). No err.
  - DATA:
    - at cnt==OVS-1, shift rxs into the shift register MSB side (LSB-first reception) and bit++;
    - after the 8th sample, go to STOP. cnt wraps in DATA without clearing.
  - STOP, at cnt==OVS-1, sample rxs:
    - if 1 and byte index=0: store byte to the low-byte holding register, byte index=1, go to GAP.
    - if 1 and byte index=1: data<={shift, low-byte holding register}, done=1 for the next cycle, go to IDLE.
    - if 0: err=1 for one cycle, data unchanged, go to HUNT.
  - GAP:
    - count idle bit times (cnt wraps, gap counter++);
    - rxs=0 goes to START with byte index=1;
    - if gap counter reaches GAP_MAX with no start, err=1 for one cycle, discard the low byte, go to IDLE.
- Latency: done rises exactly one cycle after the stop-bit sample cycle of byte 1, i.e. about 9.5 bit times after the falling edge of the second start bit, plus 2 synchroniser cycles. data and done change in the same cycle.
- done and err are never both 1; each is high for exactly one clock.
- Back-to-back words are supported: the receiver accepts a start bit immediately after the stop sample, including the transmitter's zero-gap second byte.
- data holds its value between words; it is never modified by an aborted frame.
- Reset mid-frame: all state is discarded; no done or err is produced for that frame.
- Baud tolerance: correct reception with a total mismatch of ±2 ticks accumulated over 10 bits.

Test Plan:
- Word 16'hA53C, 0x3C then 0xA5, LSB first, zero gap between bytes, ideal timing -> single done pulse, data=16'hA53C, err never asserted.
- Two words 16'h1234 then 16'hFFFF, back to back -> two done pulses, each ≥20 bit times apart; data=16'h1234 then 16'hFFFF.
- Byte 0=0x55 with stop bit driven 0 -> err pulse about 9.5 bit times after the start edge, data keeps its prior value. Receiver stays in HUNT until rx=1, then receives the next word 16'h00FF correctly.
- Byte 0=0x81 sent, then line held high for 5 bit times -> err pulse after GAP_MAX=4 bit times. A following full word 16'hC3C3 gives data=16'hC3C3.
- Glitch: rx low for 3 cycles (<OVS/2) while IDLE -> no done, no err; the next valid word is received correctly.
- rst_n pulsed low during bit 4 of byte 1 -> data=0, no done/err. Receiver waits for rx high, then decodes the next word 16'h5AA5.
